led_scan_capture: RTL and testbench
===================================

# led_scan_capture

Receive-side monitor for the 8x8 LED matrix scan interface. It watches the multiplexed `out_row_cathode` / `out_column_anode` signals driven by `top` and rebuilds the full 64-bit frame from them. Each completed frame is published on a flat bus with a one-cycle valid strobe. It is the reader for the display multiplexer: benches and on-board self-check compare its frame against `out_led_array_flat` to prove the scan path is correct.

## Interface
- `STABLE_CYCLES`, default 2. Consecutive sampling edges a row/column pattern must hold before it is committed. Legal range is 1–15.
- `in_clka`  input  1. Single clock; all state updates on the rising edge.
- `in_restart_n`  input  1. Synchronous, active-low reset.
- `in_row_cathode`  input  8. Row select, active-low. Bit r low selects row r.
- `in_column_anode`  input  8. Column data, active-high. Bit c high means the LED at (r,c) is lit.
- `out_frame_flat`  output  64. Last complete frame. Bit r*8+c is row r, column c (same mapping as `out_led_array_flat`).
- `out_frame_valid`  output  1. One-cycle pulse when `out_frame_flat` has just been updated.
- `out_frame_count`  output  8. Number of frames published; wraps 255→0.
- `out_scan_error`  output  1. Sticky flag: a row pattern with two or more low bits was seen.
- `out_rows_seen`  output  8. Rows committed since the last publish. Debug only.

## Operation
- **Pattern classes** on `in_row_cathode`:
  - Exactly one zero bit: VALID, with row index r.
  - 8'hFF: BLANK.
  - Anything else: ILLEGAL.
- **Sampling.** Each edge, the pair {`in_row_cathode`, `in_column_anode`} is compared with the pair captured on the previous edge.
  - The stability counter increments, saturating at 15, while the pair is identical and VALID.
  - Otherwise the counter loads 1 if the pair is VALID, or 0 if it is not.
- **Commit.** On the edge where the counter reaches `STABLE_CYCLES`:
  - Frame buffer row r is written with `in_column_anode`.
  - `rows_seen[r]` is set.
  - Only one commit happens per stable window. Holding the pattern longer does nothing further.
- **Publish.** On the edge where a commit makes `rows_seen` equal 8'hFF:
  - `out_frame_flat` is loaded with the buffer, including the row being committed on that edge.
  - `rows_seen` clears to 0.
  - `out_frame_count` increments.
  - `out_frame_valid` goes high for exactly the following cycle.
- **Re-visits.** A row committed again before the frame completes overwrites its buffer entry; the newest data wins. `rows_seen` is unaffected.
- **BLANK** patterns reset the stability counter and are otherwise ignored. They are not an error.
- **ILLEGAL** patterns reset the stability counter, set `out_scan_error` (held until reset), and are never committed.
- **State machine** (2 bits):
  - IDLE: counter = 0.
  - TRACK: counting, not yet committed.
  - HELD: committed, waiting for the pattern to change.
  - Transitions:
    - IDLE→TRACK when a VALID pattern appears.
    - TRACK→HELD on commit.
    - TRACK or HELD → TRACK when the pair changes to a different VALID pattern.
    - Any state → IDLE on BLANK or ILLEGAL.

## Timing
- **Reset.** While `in_restart_n` = 0 at an edge, all of the following clear to 0, and reset has priority over any commit or publish on the same edge:
  - `out_frame_flat`, `out_frame_valid`, `out_frame_count`, `out_scan_error`, `out_rows_seen`.
  - The frame buffer, the stability counter and the captured pair.
  - The state machine returns to IDLE.
- **Reset mid-frame** discards all partial rows. The first frame published after reset needs all 8 rows to be committed again.
- **Commit latency.** If a pattern is first present at edge k, it commits at edge k + `STABLE_CYCLES` − 1. With `STABLE_CYCLES` = 1 it commits on the first sampling edge.
- **Publish timing.** `out_frame_flat` changes on the completing commit edge, and `out_frame_valid` is high for the one cycle after that edge.
- **Back-to-back frames.** Consecutive `out_frame_valid` pulses are at least 8 × `STABLE_CYCLES` cycles apart.
- **Counter wrap.** `out_frame_count` wraps 255→0 without raising any flag.
- **Same-row change.** A change only in `in_column_anode` for the same row starts a new window; the row is committed again once the new data is stable.

## Test plan
- **Reset hold.** Drive `in_restart_n` = 0 for 2 cycles with arbitrary inputs → all outputs 0. With inputs held at 8'hFF, `out_frame_valid` never pulses.
- **Clean scan** (`STABLE_CYCLES` = 2). Scan rows 0..7, 2 cycles each, with column value = 8'h01 << r → `out_frame_valid` pulses once, 1 cycle after the row-7 commit edge; `out_frame_flat` = 64'h8040201008040201; `out_frame_count` = 1.
- **Glitch rejection.** Row 3 is held for only 1 cycle between full 2-cycle rows → row 3 is not committed, `out_rows_seen[3]` = 0, and no publish occurs until row 3 is later held for 2 cycles.
- **Illegal and blank handling.** Drive cathode 8'hFC for 3 cycles → `out_scan_error` = 1 and stays 1 through a following clean frame. Drive 8'hFF for 5 cycles → no error and no commit.
- **Reset mid-frame.** Commit rows 0–5, apply reset, then scan a full frame with all columns = 8'hFF → exactly one publish, `out_frame_flat` = all ones, `out_frame_count` = 1.
- **Live game cross-check.** Connect to `top`, play the restart-then-right-move sequence → after each `out_frame_valid`, `out_frame_flat` equals `out_led_array_flat` sampled at the same edge, except during the head-blink frames.

Source files
------------

// File: rtl/led_scan_capture_if.sv
// Scan-side signals between the LED matrix driver and the frame capture monitor.
// The master drives the scan lines; the slave (monitor) returns the rebuilt frame.
interface led_scan_capture_if;
  logic [7:0]  in_row_cathode;
  logic [7:0]  in_column_anode;
  logic [63:0] out_frame_flat;
  logic        out_frame_valid;
  logic [7:0]  out_frame_count;
  logic        out_scan_error;
  logic [7:0]  out_rows_seen;

  modport master (
    output in_row_cathode,
    output in_column_anode,
    input  out_frame_flat,
    input  out_frame_valid,
    input  out_frame_count,
    input  out_scan_error,
    input  out_rows_seen
  );

  modport slave (
    input  in_row_cathode,
    input  in_column_anode,
    output out_frame_flat,
    output out_frame_valid,
    output out_frame_count,
    output out_scan_error,
    output out_rows_seen
  );
endinterface

// File: rtl/led_scan_capture.sv
// Rebuilds the 8x8 LED frame from the multiplexed row/column scan lines.
// A row is committed once its pattern has been stable for STABLE_CYCLES edges.
module led_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input logic               in_clka,
  input logic               in_restart_n,
  led_scan_capture_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StTrack, StHeld} state_e;

  localparam logic [3:0] StableThr = 4'(STABLE_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  prev_row_q, prev_col_q;
  logic [63:0] frame_buf_q, frame_buf_d;
  logic [63:0] frame_flat_q;
  logic        frame_valid_q;
  logic [7:0]  frame_count_q;
  logic        scan_error_q;
  logic [7:0]  rows_seen_q, rows_seen_d;

  logic [3:0]  zeros;
  logic [2:0]  row_idx;
  logic [5:0]  row_base;
  logic        is_valid, is_blank, is_illegal, same;
  logic        commit, publish;

  always_comb begin
    zeros   = '0;
    row_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.in_row_cathode[i]) begin
        zeros   = zeros + 4'd1;
        row_idx = 3'(i);
      end
    end
    is_valid   = (zeros == 4'd1);
    is_blank   = (bus.in_row_cathode == 8'hFF);
    is_illegal = !is_valid && !is_blank;
    same       = ({bus.in_row_cathode, bus.in_column_anode} == {prev_row_q, prev_col_q});
    row_base   = {row_idx, 3'b000};

    if (is_valid && same) begin
      cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    end else if (is_valid) begin
      cnt_d = 4'd1;
    end else begin
      cnt_d = 4'd0;
    end

    // Once HELD, an unchanged pattern must not commit again, even if the count saturates.
    commit = (cnt_d == StableThr) && is_valid && (!same || state_q != StHeld);

    frame_buf_d = frame_buf_q;
    rows_seen_d = rows_seen_q;
    if (commit) begin
      frame_buf_d[row_base +: 8] = bus.in_column_anode;
      rows_seen_d                = rows_seen_q | (8'b1 << row_idx);
    end
    publish = commit && (rows_seen_d == 8'hFF);

    if (!is_valid) begin
      state_d = StIdle;
    end else if (commit) begin
      state_d = StHeld;
    end else if (!same || state_q == StIdle) begin
      state_d = StTrack;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge in_clka) begin
    if (!in_restart_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      prev_row_q    <= '0;
      prev_col_q    <= '0;
      frame_buf_q   <= '0;
      frame_flat_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
      scan_error_q  <= 1'b0;
      rows_seen_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prev_row_q    <= bus.in_row_cathode;
      prev_col_q    <= bus.in_column_anode;
      frame_buf_q   <= frame_buf_d;
      frame_valid_q <= publish;
      rows_seen_q   <= publish ? 8'h00 : rows_seen_d;
      if (publish) begin
        frame_flat_q  <= frame_buf_d;
        frame_count_q <= frame_count_q + 8'd1;
      end
      if (is_illegal) begin
        scan_error_q <= 1'b1;
      end
    end
  end

  assign bus.out_frame_flat  = frame_flat_q;
  assign bus.out_frame_valid = frame_valid_q;
  assign bus.out_frame_count = frame_count_q;
  assign bus.out_scan_error  = scan_error_q;
  assign bus.out_rows_seen   = rows_seen_q;

endmodule

// File: tb/tb_led_scan_capture.sv
// Directed bench for led_scan_capture: reset, clean scan, glitch, illegal/blank, mid-frame reset.
module tb_led_scan_capture;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   pulses;
  int   pulse_base;

  led_scan_capture_if bus ();

  led_scan_capture #(
    .STABLE_CYCLES(2)
  ) dut (
    .in_clka      (clk),
    .in_restart_n (rst_n),
    .bus          (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.out_frame_valid) pulses <= pulses + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the helper returns on a falling edge.
  task automatic drive(input logic [7:0] row, input logic [7:0] col, input int n);
    bus.in_row_cathode  = row;
    bus.in_column_anode = col;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_row(input int r, input logic [7:0] col, input int n);
    logic [7:0] sel;
    sel = ~(8'b1 << r);
    drive(sel, col, n);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    pulses = 0;
    rst_n  = 1'b0;
    bus.in_row_cathode  = 8'hFE;
    bus.in_column_anode = 8'hAA;
    @(negedge clk);
    @(negedge clk);
    check("rst_flat",  bus.out_frame_flat, 64'h0);
    check("rst_valid", 64'(bus.out_frame_valid), 64'h0);
    check("rst_count", 64'(bus.out_frame_count), 64'h0);
    check("rst_error", 64'(bus.out_scan_error), 64'h0);
    check("rst_rows",  64'(bus.out_rows_seen), 64'h0);

    drive(8'hFF, 8'h00, 1);
    rst_n = 1'b1;
    drive(8'hFF, 8'h00, 5);
    check("blank_pulses", 64'(pulses), 64'd0);
    check("blank_error",  64'(bus.out_scan_error), 64'h0);

    // Clean scan: diagonal pattern
    for (int r = 0; r < 8; r++) scan_row(r, 8'h01 << r, 2);
    check("clean_valid", 64'(bus.out_frame_valid), 64'h1);
    check("clean_flat",  bus.out_frame_flat, 64'h8040201008040201);
    check("clean_count", 64'(bus.out_frame_count), 64'd1);
    check("clean_rows",  64'(bus.out_rows_seen), 64'h0);
    drive(8'hFF, 8'h00, 1);
    check("clean_valid_drop", 64'(bus.out_frame_valid), 64'h0);
    check("clean_pulses",     64'(pulses), 64'd1);

    // Glitch: row 3 shown for a single cycle
    for (int r = 0; r < 8; r++) scan_row(r, 8'h10 + 8'(r), (r == 3) ? 1 : 2);
    check("glitch_rows",   64'(bus.out_rows_seen), 64'hF7);
    check("glitch_pulses", 64'(pulses), 64'd1);
    check("glitch_count",  64'(bus.out_frame_count), 64'd1);
    scan_row(3, 8'h33, 2);
    check("glitch_valid", 64'(bus.out_frame_valid), 64'h1);
    check("glitch_flat",  bus.out_frame_flat, 64'h1716151433121110);
    check("glitch_count2", 64'(bus.out_frame_count), 64'd2);
    check("glitch_error", 64'(bus.out_scan_error), 64'h0);

    // Illegal then blank
    drive(8'hFC, 8'h55, 3);
    check("illegal_error", 64'(bus.out_scan_error), 64'h1);
    check("illegal_rows",  64'(bus.out_rows_seen), 64'h0);
    drive(8'hFF, 8'h00, 5);
    check("blank2_rows", 64'(bus.out_rows_seen), 64'h0);
    for (int r = 0; r < 8; r++) scan_row(r, 8'h01 << r, 2);
    check("after_illegal_flat",  bus.out_frame_flat, 64'h8040201008040201);
    check("after_illegal_count", 64'(bus.out_frame_count), 64'd3);
    check("error_sticky",        64'(bus.out_scan_error), 64'h1);
    drive(8'hFF, 8'h00, 1);

    // Reset mid-frame
    for (int r = 0; r < 6; r++) scan_row(r, 8'h0F, 2);
    check("partial_rows", 64'(bus.out_rows_seen), 64'h3F);
    rst_n = 1'b0;
    drive(8'hFF, 8'h00, 2);
    check("mid_rst_rows",  64'(bus.out_rows_seen), 64'h0);
    check("mid_rst_count", 64'(bus.out_frame_count), 64'h0);
    check("mid_rst_flat",  bus.out_frame_flat, 64'h0);
    check("mid_rst_error", 64'(bus.out_scan_error), 64'h0);
    rst_n = 1'b1;
    drive(8'hFF, 8'h00, 1);
    pulse_base = pulses;
    for (int r = 0; r < 8; r++) scan_row(r, 8'hFF, 2);
    drive(8'hFF, 8'h00, 1);
    check("post_rst_flat",   bus.out_frame_flat, 64'hFFFFFFFFFFFFFFFF);
    check("post_rst_count",  64'(bus.out_frame_count), 64'd1);
    check("post_rst_pulses", 64'(pulses - pulse_base), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
